// File: rtl/xdma_axi_tx.sv
// xdma_axi_tx: AXI-Stream transmitter for the FPGA difftest transport.
// Buffers difftest beats in a first-word-fall-through FIFO. Groups them into
// fixed-length packets of PKT_BEATS beats, marking the last beat with tlast.
// A partial packet is closed with a zero pad beat (tlast=1) in two cases:
// an explicit flush pulse, or TIMEOUT idle cycles.
//
// Ports:
//   clock, reset         single clock; asynchronous active-low reset
//   in_valid/in_ready    producer handshake, in_data payload
//   flush                single-cycle request to close a partial packet
//   axi_tdata/tlast/tvalid, axi_tready   stream toward the XDMA port
//   pkt_count            tlast handshakes seen on the stream (wraps)
//   busy                 FIFO non-empty, flush pending, or packet open
module xdma_axi_tx #(
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 16,
    parameter int PKT_BEATS  = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] axi_tdata,
    output logic                  axi_tlast,
    output logic                  axi_tvalid,
    input  logic                  axi_tready,
    output logic [31:0]           pkt_count,
    output logic                  busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(PKT_BEATS);
    localparam int IW = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_BEATS - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    // FIFO storage: bit DATA_WIDTH holds tlast, the rest is payload
    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic                empty, full;

    logic [BW-1:0]       beat_cnt, beat_nxt;
    logic [IW-1:0]       idle_cnt, idle_nxt;
    logic                flush_pend, fp_nxt;

    logic                accept, pad_push, pop, push, beat_last, idle_cond, fire;
    logic [DATA_WIDTH:0] push_ent, head;

    // Pointers carry one extra wrap bit so full and empty can be told apart
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // The reset term keeps in_ready low while reset is held. The other terms
    // are registered state, so axi_tready has no path into in_ready.
    assign in_ready  = reset & ~full & ~flush_pend;
    assign accept    = in_valid & in_ready;
    // A pad beat and an input accept never share a cycle: in_ready is low
    // whenever flush_pend is set.
    assign pad_push  = flush_pend & ~full;
    assign pop       = axi_tvalid & axi_tready;
    assign beat_last = (beat_cnt == LAST_BEAT);
    assign idle_cond = ~accept & ~flush_pend & (beat_cnt != '0);

    assign head       = mem[rd_ptr[AW-1:0]];
    assign axi_tvalid = ~empty;
    assign axi_tdata  = empty ? '0 : head[DATA_WIDTH-1:0];
    assign axi_tlast  = empty ? 1'b0 : head[DATA_WIDTH];
    assign busy       = ~empty | flush_pend | (beat_cnt != '0);

    always_comb begin
        push     = 1'b0;
        push_ent = '0;
        beat_nxt = beat_cnt;
        fp_nxt   = flush_pend;
        fire     = 1'b0;
        idle_nxt = '0;

        if (accept) begin
            push     = 1'b1;
            push_ent = {beat_last, in_data};
            beat_nxt = beat_last ? '0 : beat_cnt + BW'(1);
        end else if (pad_push) begin
            push     = 1'b1;
            push_ent = {1'b1, {DATA_WIDTH{1'b0}}};
            beat_nxt = '0;
            fp_nxt   = 1'b0;
        end

        // Idle counter restarts on any accept or when no packet is open.
        // Reaching TIMEOUT-1 requests a flush and restarts the count.
        if (idle_cond) begin
            if (TIMEOUT != 0 && idle_cnt == IDLE_LAST) begin
                fire = 1'b1;
            end else begin
                idle_nxt = idle_cnt + IW'(1);
            end
        end

        // A flush is tested against the beat count after this cycle's accept.
        // So a flush that lands on the closing beat needs no pad.
        // Extra flushes while one is already pending are absorbed here.
        if (!flush_pend && (flush || fire) && beat_nxt != '0) begin
            fp_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            beat_cnt   <= '0;
            idle_cnt   <= '0;
            flush_pend <= 1'b0;
            pkt_count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            beat_cnt   <= beat_nxt;
            idle_cnt   <= idle_nxt;
            flush_pend <= fp_nxt;
            if (pop && axi_tlast) pkt_count <= pkt_count + 32'd1;
        end
    end

    // The storage array is not reset. Contents only become visible behind
    // the pointers, which are reset.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_ent;
    end

endmodule

// File: tb/tb_xdma_axi_tx.sv
// Self-checking bench for xdma_axi_tx.
// A queue-based reference model predicts FIFO occupancy, packet grouping,
// flush/timeout pad insertion, and the expected stream. The model pushes the
// predicted beats into a scoreboard queue. A separate monitor pops the queue
// whenever the DUT completes a stream handshake.
module tb_xdma_axi_tx;

    localparam int DW    = 512;
    localparam int DEPTH = 16;
    localparam int PKT   = 8;
    localparam int TO    = 4;

    logic          clock, reset, in_valid, in_ready, flush;
    logic [DW-1:0] in_data, axi_tdata;
    logic          axi_tlast, axi_tvalid, axi_tready, busy;
    logic [31:0]   pkt_count;

    xdma_axi_tx #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PKT_BEATS(PKT), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .axi_tdata(axi_tdata), .axi_tlast(axi_tlast),
        .axi_tvalid(axi_tvalid), .axi_tready(axi_tready), .pkt_count(pkt_count), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0, n_pass = 0;

    // Reference model state
    logic [DW:0] exp_q[$];
    int          m_occ = 0, m_beats = 0, m_idle = 0, exp_pkt = 0, dut_acc = 0;
    bit          m_fp = 0;

    task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] rand512();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_clear();
        m_occ = 0; m_beats = 0; m_idle = 0; m_fp = 0; exp_pkt = 0;
        exp_q.delete();
    endtask

    // One clock cycle. Inputs are applied, outputs are checked at the
    // negedge, and the model advances by the spec rules.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic f, input logic tr);
        logic acc, pop, push, fire, fp0;
        logic [DW:0] ent;
        in_valid = v; in_data = d; flush = f; axi_tready = tr;
        @(negedge clock);
        chk("in_ready", in_ready, (m_occ < DEPTH) && !m_fp);
        chk("tvalid",   axi_tvalid, m_occ != 0);
        chk("busy",     busy, (m_occ != 0) || m_fp || (m_beats != 0));
        if (v && in_ready) dut_acc++;
        acc  = v && (m_occ < DEPTH) && !m_fp;
        pop  = (m_occ != 0) && tr;
        fp0  = m_fp;
        push = 1'b0;
        fire = 1'b0;
        ent  = '0;
        if (acc) begin
            ent = {m_beats == PKT - 1, d};
            m_beats = (m_beats == PKT - 1) ? 0 : m_beats + 1;
            push = 1'b1;
        end else if (fp0 && m_occ < DEPTH) begin
            ent = {1'b1, {DW{1'b0}}};
            m_beats = 0; m_fp = 0; push = 1'b1;
        end
        if (!acc && !fp0 && m_beats != 0) begin
            if (m_idle == TO - 1) begin fire = 1'b1; m_idle = 0; end
            else m_idle++;
        end else m_idle = 0;
        if (!fp0 && (f || fire) && m_beats != 0) m_fp = 1;
        if (push) exp_q.push_back(ent);
        m_occ = m_occ + int'(push) - int'(pop);
        @(posedge clock); #1;
    endtask

    // Monitor: decoupled from stimulus, compares each stream handshake.
    always @(negedge clock) begin
        if (reset) begin
            chk("pkt_count", pkt_count, exp_pkt);
            if (!axi_tvalid) chk("idle_out", {axi_tlast, axi_tdata}, '0);
            if (axi_tvalid && axi_tready) begin
                if (exp_q.size() == 0) begin
                    chk("stream_extra", {axi_tlast, axi_tdata}, {1'b1, {DW{1'b1}}});
                end else begin
                    chk("stream_beat", {axi_tlast, axi_tdata}, exp_q.pop_front());
                    if (axi_tlast) exp_pkt++;
                end
            end
        end
    end

    initial begin
        reset = 1'b0; in_valid = 0; in_data = '0; flush = 0; axi_tready = 0;
        #1;
        chk("rst_tvalid", axi_tvalid, 0);
        chk("rst_out", {axi_tlast, axi_tdata}, '0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt", pkt_count, 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // One full packet, data = index, tready high
        for (int i = 0; i < PKT; i++) cycle(1, DW'(i), 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, '0, 0, 1);
        chk("pkt1_count", pkt_count, 1);

        // Fill with tready low: only DEPTH of 20 are accepted
        dut_acc = 0;
        for (int i = 0; i < 20; i++) cycle(1, DW'(i), 0, 0);
        chk("fill_accepts", dut_acc, DEPTH);
        chk("fill_in_ready", in_ready, 0);
        for (int i = 0; i < 20; i++) cycle(0, '0, 0, 1);
        chk("fill_pkts", pkt_count, 3);

        // 3 beats then flush -> pad beat
        for (int i = 0; i < 3; i++) cycle(1, DW'(100 + i), 0, 1);
        cycle(0, '0, 1, 1);
        for (int i = 0; i < 5; i++) cycle(0, '0, 0, 1);
        chk("flush_pkts", pkt_count, 4);

        // Flush on the closing beat, then flush with nothing open
        for (int i = 0; i < PKT - 1; i++) cycle(1, DW'(200 + i), 0, 1);
        cycle(1, DW'(207), 1, 1);
        cycle(0, '0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, '0, 0, 1);
        chk("noflush_pkts", pkt_count, 5);

        // Timeout: 2 beats then idle
        cycle(1, DW'(300), 0, 1);
        cycle(1, DW'(301), 0, 1);
        for (int i = 0; i < 10; i++) cycle(0, '0, 0, 1);
        chk("timeout_pkts", pkt_count, 6);
        chk("timeout_busy", busy, 0);

        // Randomized traffic
        for (int i = 0; i < 800; i++)
            cycle($urandom_range(99) < 60, rand512(), $urandom_range(99) < 3,
                  $urandom_range(99) < 55);
        for (int i = 0; i < 40; i++) cycle(0, '0, 0, 1);
        chk("rand_drained", exp_q.size(), 0);

        // Reset with 5 beats buffered and tvalid high
        for (int i = 0; i < 5; i++) cycle(1, DW'(400 + i), 0, 0);
        chk("pre_rst_tvalid", axi_tvalid, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_tvalid", axi_tvalid, 0);
        chk("mid_rst_pkt", pkt_count, 0);
        chk("mid_rst_busy", busy, 0);
        model_clear();
        @(posedge clock); #1;
        reset = 1'b1;
        for (int i = 0; i < PKT; i++) cycle(1, DW'(500 + i), 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, '0, 0, 1);
        chk("post_rst_pkt", pkt_count, 1);
        chk("post_rst_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/xdma_axi_tx.md
Name: xdma_axi_tx

Overview:
- AXI-Stream transmitter for the FPGA difftest transport. It runs in the opposite direction to the XDMA card-to-host receive path.
- It accepts 512-bit difftest beats from the packing logic and buffers them in a first-word-fall-through FIFO.
- It groups the beats into fixed-length packets and drives them toward the XDMA H2C/C2H stream port with tvalid/tready/tlast.
- An explicit flush or an idle timeout closes a partial packet by appending a zero pad beat.

Parameters:
- DATA_WIDTH, 512: beat width; fixed to the XDMA stream width.
- DEPTH, 16: FIFO entries; must be a power of two, ≥ 2.
- PKT_BEATS, 8: beats per full packet, including the tlast beat; must be ≥ 2.
- TIMEOUT, 1024: idle cycles with a partial packet before an automatic flush; 0 disables the timeout.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer beat valid.
- in_ready  out  1  producer beat accepted when in_valid & in_ready.
- in_data  in  DATA_WIDTH  producer beat payload.
- flush  in  1  single-cycle request to close the current partial packet.
- axi_tdata  out  512  stream payload.
- axi_tlast  out  1  last beat of a packet.
- axi_tvalid  out  1  stream beat valid.
- axi_tready  in  1  XDMA side ready.
- pkt_count  out  32  count of packets completed on the stream side, i.e. tlast handshakes; wraps at 2^32.
- busy  out  1  high when the FIFO is non-empty, a flush is pending, or beat_cnt != 0.

Behaviour:

Reset
- While reset is low, and immediately on assertion (asynchronous): FIFO empty, beat_cnt = 0, idle_cnt = 0, flush_pend = 0, pkt_count = 0.
- Outputs in reset: axi_tvalid = 0, axi_tlast = 0, axi_tdata = 0, in_ready = 0, busy = 0.
- Assertion mid-packet discards all buffered beats; no partial tlast is emitted.
- First cycle after deassertion: in_ready = 1.

FIFO
- DEPTH entries of {tlast, data}; first-word-fall-through.
- Outputs: axi_tvalid = !empty; axi_tdata and axi_tlast come from the head entry, or are 0 when empty.
- Pop on axi_tvalid & axi_tready.
- Push and pop in the same cycle are legal at any occupancy, including full (pop frees the slot) and empty (no bypass; the pushed beat appears on the next cycle).
- Entry latency: 1 cycle.
- Once axi_tvalid is high, axi_tdata and axi_tlast stay stable until the handshake.

in_ready
- in_ready = !full & !flush_pend, computed from registered state only.
- It has no combinational dependency on axi_tready.

Packetizer (write side)
- beat_cnt counts 0..PKT_BEATS-1.
- On an accepted input beat, the entry's tlast = (beat_cnt == PKT_BEATS-1).
  - If tlast = 1, beat_cnt → 0; otherwise beat_cnt increments.

Flush
- flush_pend sets when the flush pulse arrives, or when the timeout fires, and beat_cnt != 0 after the current cycle's update.
- Flush with beat_cnt == 0 is ignored.
- Flush in the same cycle as an input accept: the accepted beat counts first.
  - If that beat closed the packet, no pad beat is generated.
  - Otherwise a pad beat follows.
- While flush_pend = 1 and the FIFO is not full: push a pad beat {tlast = 1, data = 0}, then beat_cnt → 0 and flush_pend → 0.
- While flush_pend = 1 and the FIFO is full, flush_pend holds until space frees.
- Further flush pulses while flush_pend = 1 are absorbed.

Timeout
- idle_cnt increments each cycle when beat_cnt != 0, no accept occurs, and flush_pend = 0.
- Any accept, or beat_cnt == 0, clears idle_cnt.
- When idle_cnt reaches TIMEOUT-1 and TIMEOUT != 0, flush_pend sets and idle_cnt clears.

pkt_count
- Increments by 1 on axi_tvalid & axi_tready & axi_tlast.

Widths
- All counters are unsigned.
- beat_cnt is $clog2(PKT_BEATS) bits; idle_cnt is max(1, $clog2(TIMEOUT+1)) bits.
- FIFO pointers are $clog2(DEPTH)+1 bits; full/empty are derived from the pointer MSB comparison.

Test Plan:
- Reset then 8 beats, data = beat index 0..7, with axi_tready = 1 → 8 stream beats in order, tlast only on beat 7, first tvalid 1 cycle after first accept, pkt_count = 1.
- axi_tready = 0, 20 input beats offered → exactly 16 accepted, in_ready = 0 afterwards. Then axi_tready = 1 → beats 0..15 drain intact, with tlast on beats 7 and 15; in_ready reasserts on the cycle after the first pop.
- 3 beats then a flush pulse → stream carries 3 data beats with tlast = 0, then a pad beat with data = 0 and tlast = 1; pkt_count = 1; in_ready = 0 for exactly 1 cycle.
- Flush coincident with acceptance of the 8th beat → no pad beat, one 8-beat packet; a flush with beat_cnt == 0 → no stream activity.
- TIMEOUT = 4, 2 beats then idle → pad beat pushed in the 5th cycle after the last accept; busy falls after the pad handshake.
- Reset asserted with 5 beats buffered and axi_tvalid high → axi_tvalid drops without a clock edge, pkt_count = 0; after release, a fresh 8-beat packet carries tlast on its 8th beat.
